// File: rtl/md_unit_if.sv
// md_unit_if: E-stage handshake and HI/LO result bundle between the pipeline
// and the multiply/divide unit.
interface md_unit_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [3:0]       op;
    logic             flush;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             stall;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic [WIDTH-1:0] mf_data;

    modport master (
        output start, op, flush, a, b,
        input  busy, stall, hi, lo, mf_data
    );

    modport slave (
        input  start, op, flush, a, b,
        output busy, stall, hi, lo, mf_data
    );
endinterface

// File: rtl/md_unit.sv
// md_unit: MIPS-style HI/LO multiply/divide unit with a fixed busy window,
// hazard stall request, and flush/reset abort of in-flight operations.
module md_unit #(
    parameter int WIDTH       = 32,
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input logic      clk,
    input logic      reset_n,
    md_unit_if.slave bus
);
    localparam logic [3:0] OP_MULT  = 4'd0;
    localparam logic [3:0] OP_MULTU = 4'd1;
    localparam logic [3:0] OP_DIV   = 4'd2;
    localparam logic [3:0] OP_DIVU  = 4'd3;
    localparam logic [3:0] OP_MFHI  = 4'd4;
    localparam logic [3:0] OP_MFLO  = 4'd5;
    localparam logic [3:0] OP_MTHI  = 4'd6;
    localparam logic [3:0] OP_MTLO  = 4'd7;

    localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0] ONE      = {{(WIDTH-1){1'b0}}, 1'b1};

    typedef enum logic {S_IDLE, S_BUSY} state_t;

    state_t           state, state_next;
    logic [5:0]       count, count_next;
    logic [3:0]       op_q;
    logic [WIDTH-1:0] a_q, b_q, hi_q, lo_q;
    logic             accept, commit, is_multi, busy;
    logic [WIDTH-1:0] res_hi, res_lo;
    logic [2*WIDTH-1:0] prod_s, prod_u;
    logic             div_zero, div_ovf;
    logic [WIDTH-1:0] div_b_s, div_b_u, quot_s, rem_s, quot_u, rem_u;

    assign busy     = (state == S_BUSY);
    assign is_multi = (bus.op[3:2] == 2'b00);

    always_comb begin
        state_next = state;
        count_next = count;
        accept     = 1'b0;
        commit     = 1'b0;
        case (state)
            S_IDLE: begin
                if (bus.start && !bus.flush) begin
                    accept = 1'b1;
                    if (is_multi) begin
                        state_next = S_BUSY;
                        count_next = (bus.op[1] == 1'b0) ? 6'(MULT_CYCLES) : 6'(DIV_CYCLES);
                    end
                end
            end
            S_BUSY: begin
                // Flush wins even on the final edge, so no result is committed.
                if (bus.flush) begin
                    state_next = S_IDLE;
                    count_next = '0;
                end else begin
                    count_next = count - 6'd1;
                    if (count <= 6'd1) begin
                        commit     = 1'b1;
                        state_next = S_IDLE;
                        count_next = '0;
                    end
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    // Full-width products: lower 2*WIDTH bits of sign- or zero-extended operands.
    assign prod_s = {{WIDTH{a_q[WIDTH-1]}}, a_q} * {{WIDTH{b_q[WIDTH-1]}}, b_q};
    assign prod_u = {{WIDTH{1'b0}}, a_q} * {{WIDTH{1'b0}}, b_q};

    // Substitute a harmless divisor for the cases whose result is overridden.
    assign div_zero = (b_q == '0);
    assign div_ovf  = (a_q == MOST_NEG) && (b_q == '1);
    assign div_b_s  = (div_zero || div_ovf) ? ONE : b_q;
    assign div_b_u  = div_zero ? ONE : b_q;
    assign quot_s   = $signed(a_q) / $signed(div_b_s);
    assign rem_s    = $signed(a_q) % $signed(div_b_s);
    assign quot_u   = a_q / div_b_u;
    assign rem_u    = a_q % div_b_u;

    always_comb begin
        res_hi = hi_q;
        res_lo = lo_q;
        case (op_q)
            OP_MULT:  {res_hi, res_lo} = prod_s;
            OP_MULTU: {res_hi, res_lo} = prod_u;
            OP_DIV: begin
                if (div_ovf) begin
                    res_lo = MOST_NEG;
                    res_hi = '0;
                end else if (!div_zero) begin
                    res_lo = quot_s;
                    res_hi = rem_s;
                end
            end
            OP_DIVU: begin
                if (!div_zero) begin
                    res_lo = quot_u;
                    res_hi = rem_u;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_IDLE;
            count <= '0;
            op_q  <= '0;
            a_q   <= '0;
            b_q   <= '0;
            hi_q  <= '0;
            lo_q  <= '0;
        end else begin
            state <= state_next;
            count <= count_next;
            if (accept && is_multi) begin
                op_q <= bus.op;
                a_q  <= bus.a;
                b_q  <= bus.b;
            end
            if (commit) begin
                hi_q <= res_hi;
                lo_q <= res_lo;
            end else if (accept && bus.op == OP_MTHI) begin
                hi_q <= bus.a;
            end else if (accept && bus.op == OP_MTLO) begin
                lo_q <= bus.a;
            end
        end
    end

    always_comb begin
        case (bus.op)
            OP_MFHI: bus.mf_data = hi_q;
            OP_MFLO: bus.mf_data = lo_q;
            default: bus.mf_data = '0;
        endcase
    end

    assign bus.busy  = busy;
    assign bus.stall = bus.start && !bus.op[3] && busy;
    assign bus.hi    = hi_q;
    assign bus.lo    = lo_q;
endmodule

// File: tb/tb_md_unit.sv
// tb_md_unit: table-driven, hand-written and randomized checks of md_unit
// against a cycle-level behavioural model of the HI/LO unit.
module tb_md_unit;
    localparam int W      = 32;
    localparam int MULT_N = 5;
    localparam int DIV_N  = 10;

    logic clk;
    logic reset_n;

    md_unit_if #(.WIDTH(W)) bus ();
    md_unit_if #(.WIDTH(W)) bus1 ();

    md_unit #(.WIDTH(W), .MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
        .clk(clk), .reset_n(reset_n), .bus(bus)
    );

    md_unit #(.WIDTH(W), .MULT_CYCLES(1), .DIV_CYCLES(63)) dut_edge (
        .clk(clk), .reset_n(reset_n), .bus(bus1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    int total_checks  = 0;
    int passed_checks = 0;

    // Model: architectural HI/LO plus cycles left and the result pending commit.
    logic [31:0] m_hi, m_lo, p_hi, p_lo;
    int          m_left;
    bit          p_write;

    logic        cur_start, cur_flush;
    logic [3:0]  cur_op;
    logic [31:0] cur_a, cur_b;

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        int          cycles;
        logic [31:0] exp_hi;
        logic [31:0] exp_lo;
    } vec_t;

    vec_t vecs[11];

    task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_checks++;
        if (act === exp) passed_checks++;
        else $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    endtask

    task automatic modelReset();
        m_hi    = '0;
        m_lo    = '0;
        m_left  = 0;
        p_write = 1'b0;
    endtask

    task automatic modelEdge(input logic s, input logic [3:0] o, input logic f,
                             input logic [31:0] av, input logic [31:0] bv);
        longint sa, sb, ua, ub, q, r;
        logic [63:0] pr;
        sa = longint'($signed(av));
        sb = longint'($signed(bv));
        ua = longint'({32'd0, av});
        ub = longint'({32'd0, bv});
        if (m_left > 0) begin
            if (f) m_left = 0;
            else begin
                m_left--;
                if (m_left == 0 && p_write) begin
                    m_hi = p_hi;
                    m_lo = p_lo;
                end
            end
        end else if (s && !f) begin
            case (o)
                4'd0: begin pr = 64'(sa * sb); {p_hi, p_lo} = pr; p_write = 1'b1; m_left = MULT_N; end
                4'd1: begin pr = 64'(ua * ub); {p_hi, p_lo} = pr; p_write = 1'b1; m_left = MULT_N; end
                4'd2: begin
                    m_left  = DIV_N;
                    p_write = (bv != 0);
                    if (p_write) begin
                        q = sa / sb; r = sa % sb;
                        p_lo = q[31:0]; p_hi = r[31:0];
                    end
                end
                4'd3: begin
                    m_left  = DIV_N;
                    p_write = (bv != 0);
                    if (p_write) begin
                        q = ua / ub; r = ua % ub;
                        p_lo = q[31:0]; p_hi = r[31:0];
                    end
                end
                4'd6: m_hi = av;
                4'd7: m_lo = av;
                default: ;
            endcase
        end
    endtask

    task automatic applyStimulus(input logic s, input logic [3:0] o, input logic f,
                                 input logic [31:0] av, input logic [31:0] bv);
        cur_start = s; cur_op = o; cur_flush = f; cur_a = av; cur_b = bv;
        bus.start = s; bus.op = o; bus.flush = f; bus.a = av; bus.b = bv;
        #2;
    endtask

    task automatic checkOutput();
        logic        exp_busy, exp_stall;
        logic [31:0] exp_mf;
        exp_busy  = (m_left > 0);
        exp_stall = cur_start && (cur_op < 4'd8) && exp_busy;
        exp_mf    = (cur_op == 4'd4) ? m_hi : (cur_op == 4'd5) ? m_lo : 32'd0;
        checkVal("busy", 32'(bus.busy), 32'(exp_busy));
        checkVal("stall", 32'(bus.stall), 32'(exp_stall));
        checkVal("hi", bus.hi, m_hi);
        checkVal("lo", bus.lo, m_lo);
        checkVal("mf_data", bus.mf_data, exp_mf);
    endtask

    task automatic clockEdge();
        @(posedge clk);
        modelEdge(cur_start, cur_op, cur_flush, cur_a, cur_b);
        #1;
    endtask

    task automatic step(input logic s, input logic [3:0] o, input logic f,
                        input logic [31:0] av, input logic [31:0] bv);
        applyStimulus(s, o, f, av, bv);
        checkOutput();
        clockEdge();
    endtask

    task automatic drain(input string name);
        int k;
        k = 0;
        while (bus.busy && k < 80) begin
            step(1'b0, 4'd0, 1'b0, 32'd0, 32'd0);
            k++;
        end
        if (k >= 80) checkVal({name, "_drain_timeout"}, 32'(bus.busy), 32'd0);
    endtask

    initial begin
        int n;
        vecs[0]  = '{4'd0, 32'hFFFFFFFF, 32'd2,        MULT_N, 32'hFFFFFFFF, 32'hFFFFFFFE};
        vecs[1]  = '{4'd1, 32'hFFFFFFFF, 32'd2,        MULT_N, 32'h00000001, 32'hFFFFFFFE};
        vecs[2]  = '{4'd2, 32'hFFFFFFF9, 32'd2,        DIV_N,  32'hFFFFFFFF, 32'hFFFFFFFD};
        vecs[3]  = '{4'd3, 32'd7,        32'd0,        DIV_N,  32'hFFFFFFFF, 32'hFFFFFFFD};
        vecs[4]  = '{4'd6, 32'h12345678, 32'd0,        0,      32'h12345678, 32'hFFFFFFFD};
        vecs[5]  = '{4'd7, 32'hCAFEBABE, 32'd0,        0,      32'h12345678, 32'hCAFEBABE};
        vecs[6]  = '{4'd2, 32'h80000000, 32'hFFFFFFFF, DIV_N,  32'h00000000, 32'h80000000};
        vecs[7]  = '{4'd3, 32'd100,      32'd7,        DIV_N,  32'h00000002, 32'h0000000E};
        vecs[8]  = '{4'd2, 32'd7,        32'hFFFFFFFE, DIV_N,  32'h00000001, 32'hFFFFFFFD};
        vecs[9]  = '{4'd9, 32'd5,        32'd5,        0,      32'h00000001, 32'hFFFFFFFD};
        vecs[10] = '{4'd0, 32'h00010000, 32'h00010000, MULT_N, 32'h00000001, 32'h00000000};

        reset_n = 1'b0;
        bus.start = 0; bus.op = 0; bus.flush = 0; bus.a = 0; bus.b = 0;
        bus1.start = 0; bus1.op = 0; bus1.flush = 0; bus1.a = 0; bus1.b = 0;
        cur_start = 0; cur_op = 0; cur_flush = 0; cur_a = 0; cur_b = 0;
        modelReset();

        #12;
        checkVal("reset_hi", bus.hi, 32'd0);
        checkVal("reset_lo", bus.lo, 32'd0);
        checkVal("reset_busy", 32'(bus.busy), 32'd0);
        reset_n = 1'b1;

        // Start presented before the first edge after release must be taken.
        step(1'b1, 4'd6, 1'b0, 32'hA5A5A5A5, 32'd0);
        checkVal("first_edge_mthi", bus.hi, 32'hA5A5A5A5);

        for (int i = 0; i < 11; i++) begin
            step(1'b1, vecs[i].op, 1'b0, vecs[i].a, vecs[i].b);
            n = 0;
            for (int k = 0; k < 80 && bus.busy; k++) begin
                n++;
                step(1'b0, 4'd0, 1'b0, 32'd0, 32'd0);
            end
            checkVal($sformatf("vec%0d_busy_cycles", i), 32'(n), 32'(vecs[i].cycles));
            checkVal($sformatf("vec%0d_hi", i), bus.hi, vecs[i].exp_hi);
            checkVal($sformatf("vec%0d_lo", i), bus.lo, vecs[i].exp_lo);
        end

        // mflo issued two cycles into a mult: stalled until the product lands.
        step(1'b1, 4'd0, 1'b0, 32'd3, 32'd5);
        step(1'b0, 4'd0, 1'b0, 32'd0, 32'd0);
        step(1'b0, 4'd0, 1'b0, 32'd0, 32'd0);
        n = 0;
        for (int k = 0; k < 20; k++) begin
            applyStimulus(1'b1, 4'd5, 1'b0, 32'd0, 32'd0);
            checkOutput();
            if (!bus.stall) break;
            n++;
            clockEdge();
        end
        checkVal("mflo_stall_cycles", 32'(n), 32'd3);
        checkVal("mflo_data", bus.mf_data, 32'd15);
        checkVal("mflo_stall_low", 32'(bus.stall), 32'd0);
        clockEdge();

        // mthi while busy is stalled and must not touch HI.
        step(1'b1, 4'd6, 1'b0, 32'h11112222, 32'd0);
        step(1'b1, 4'd0, 1'b0, 32'd2, 32'd2);
        applyStimulus(1'b1, 4'd6, 1'b0, 32'hDEADBEEF, 32'd0);
        checkOutput();
        checkVal("mthi_busy_stall", 32'(bus.stall), 32'd1);
        clockEdge();
        checkVal("mthi_busy_hi", bus.hi, 32'h11112222);
        drain("mthi_busy");
        checkVal("mthi_busy_mult_lo", bus.lo, 32'd4);

        // Flush on the third busy cycle of a divide.
        step(1'b1, 4'd2, 1'b0, 32'd100, 32'd3);
        step(1'b0, 4'd0, 1'b0, 32'd0, 32'd0);
        step(1'b0, 4'd0, 1'b0, 32'd0, 32'd0);
        step(1'b0, 4'd0, 1'b1, 32'd0, 32'd0);
        checkVal("flush_busy", 32'(bus.busy), 32'd0);
        checkVal("flush_hi", bus.hi, 32'd0);
        checkVal("flush_lo", bus.lo, 32'd4);
        step(1'b1, 4'd0, 1'b0, 32'd6, 32'd7);
        checkVal("post_flush_accept", 32'(bus.busy), 32'd1);
        drain("post_flush");
        checkVal("post_flush_lo", bus.lo, 32'd42);

        // Flush and start together: nothing accepted.
        step(1'b1, 4'd7, 1'b1, 32'h99, 32'd0);
        checkVal("flush_prio_lo", bus.lo, 32'd42);
        step(1'b1, 4'd0, 1'b1, 32'd5, 32'd5);
        checkVal("flush_prio_busy", 32'(bus.busy), 32'd0);

        // Flush on the final counter edge: no commit.
        step(1'b1, 4'd0, 1'b0, 32'd9, 32'd9);
        for (int k = 0; k < MULT_N - 1; k++) step(1'b0, 4'd0, 1'b0, 32'd0, 32'd0);
        step(1'b0, 4'd0, 1'b1, 32'd0, 32'd0);
        step(1'b0, 4'd0, 1'b0, 32'd0, 32'd0);
        checkVal("final_flush_busy", 32'(bus.busy), 32'd0);
        checkVal("final_flush_lo", bus.lo, 32'd42);

        // Reset pulse in the middle of a multu.
        step(1'b1, 4'd1, 1'b0, 32'd7, 32'd9);
        step(1'b0, 4'd0, 1'b0, 32'd0, 32'd0);
        step(1'b0, 4'd0, 1'b0, 32'd0, 32'd0);
        #2;
        reset_n = 1'b0;
        #1;
        checkVal("rst_mid_hi", bus.hi, 32'd0);
        checkVal("rst_mid_lo", bus.lo, 32'd0);
        checkVal("rst_mid_busy", 32'(bus.busy), 32'd0);
        modelReset();
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        for (int k = 0; k < 8; k++) step(1'b0, 4'd0, 1'b0, 32'd0, 32'd0);
        checkVal("no_late_commit_lo", bus.lo, 32'd0);

        for (int i = 0; i < 400; i++) begin
            logic        s, f;
            logic [3:0]  o;
            logic [31:0] av, bv;
            s  = ($urandom_range(0, 2) != 0);
            o  = 4'($urandom_range(0, 9));
            f  = ($urandom_range(0, 15) == 0);
            av = $urandom();
            bv = $urandom();
            case ($urandom_range(0, 7))
                0: bv = 32'd0;
                1: begin av = 32'h80000000; bv = 32'hFFFFFFFF; end
                2: bv = 32'($urandom_range(1, 9));
                default: ;
            endcase
            step(s, o, f, av, bv);
        end

        // Latency extremes on the second instance: N=1 mult, N=63 divu.
        applyStimulus(1'b0, 4'd0, 1'b0, 32'd0, 32'd0);
        bus1.start = 1; bus1.op = 4'd0; bus1.a = 32'd3; bus1.b = 32'd4;
        @(posedge clk); #1;
        bus1.start = 0;
        checkVal("n1_busy_on", 32'(bus1.busy), 32'd1);
        @(posedge clk); #1;
        checkVal("n1_busy_off", 32'(bus1.busy), 32'd0);
        checkVal("n1_lo", bus1.lo, 32'd12);
        bus1.start = 1; bus1.op = 4'd3; bus1.a = 32'd1000; bus1.b = 32'd10;
        @(posedge clk); #1;
        bus1.start = 0;
        n = 0;
        for (int k = 0; k < 80 && bus1.busy; k++) begin
            n++;
            @(posedge clk); #1;
        end
        checkVal("n63_busy_cycles", 32'(n), 32'd63);
        checkVal("n63_lo", bus1.lo, 32'd100);
        checkVal("n63_hi", bus1.hi, 32'd0);

        $display("%0d/%0d checks passed", passed_checks, total_checks);
        $finish;
    end
endmodule
